// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: selects exceptions/interrupts/mret at execute,
// drains the pipe, then updates the M-mode trap CSRs and redirects fetch.
module trap_controller #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_MTVEC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_inst,
  input  logic        ecall,
  input  logic        ebreak,
  input  logic        mret,
  input  logic        illegal_instr,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        trap_active
);

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;
  localparam logic [11:0] A_MIP     = 12'h344;

  typedef enum logic [1:0] {IDLE, DRAIN, ENTER, RETURN} state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic        ret_q;
  logic [31:0] cause_q, pc_q, tval_q;
  logic        mie_q, mpie_q, meie_q, mtie_q;
  logic [31:0] mtvec_q, mepc_q, mcause_q, mtval_q;

  logic        evt_hit, evt_ret;
  logic [31:0] evt_cause, evt_tval;
  logic        irq_e, irq_t;

  assign irq_e = mie_q & meie_q & irq_ext;
  assign irq_t = mie_q & mtie_q & irq_timer;

  // Decoder flags outrank interrupts, so an interrupt only fires on a clean instruction.
  always_comb begin
    evt_hit   = 1'b0;
    evt_ret   = 1'b0;
    evt_cause = 32'h0;
    evt_tval  = 32'h0;
    if (state_q == IDLE && ex_valid) begin
      if (illegal_instr) begin
        evt_hit = 1'b1; evt_cause = 32'd2; evt_tval = ex_inst;
      end else if (ebreak) begin
        evt_hit = 1'b1; evt_cause = 32'd3; evt_tval = ex_pc;
      end else if (ecall) begin
        evt_hit = 1'b1; evt_cause = 32'd11;
      end else if (mret) begin
        evt_hit = 1'b1; evt_ret = 1'b1;
      end else if (irq_e) begin
        evt_hit = 1'b1; evt_cause = 32'h8000_000B;
      end else if (irq_t) begin
        evt_hit = 1'b1; evt_cause = 32'h8000_0007;
      end
    end
  end

  assign flush          = evt_hit;
  assign stall          = evt_hit | (state_q != IDLE);
  assign trap_active    = (state_q != IDLE);
  assign redirect_valid = (state_q == ENTER) || (state_q == RETURN);

  always_comb begin
    redirect_pc = 32'h0;
    if (state_q == ENTER) begin
      redirect_pc = {mtvec_q[31:2], 2'b00};
      if (mtvec_q[1:0] == 2'b01 && cause_q[31])
        redirect_pc = redirect_pc + {26'h0, cause_q[3:0], 2'b00};
    end else if (state_q == RETURN) begin
      redirect_pc = mepc_q;
    end
  end

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      A_MSTATUS: csr_rdata = {24'h0, mpie_q, 3'b000, mie_q, 3'b000};
      A_MIE:     csr_rdata = {20'h0, meie_q, 3'b000, mtie_q, 7'h0};
      A_MTVEC:   csr_rdata = mtvec_q;
      A_MEPC:    csr_rdata = mepc_q;
      A_MCAUSE:  csr_rdata = mcause_q;
      A_MTVAL:   csr_rdata = mtval_q;
      A_MIP:     csr_rdata = {20'h0, irq_ext, 3'b000, irq_timer, 7'h0};
      default:   csr_rdata = 32'h0;
    endcase
  end

  // Pipeline CSR writes land first; trap entry/return updates below override them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      ret_q    <= 1'b0;
      cause_q  <= 32'h0;
      pc_q     <= 32'h0;
      tval_q   <= 32'h0;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      meie_q   <= 1'b0;
      mtie_q   <= 1'b0;
      mtvec_q  <= RESET_MTVEC;
      mepc_q   <= 32'h0;
      mcause_q <= 32'h0;
      mtval_q  <= 32'h0;
    end else begin
      if (csr_we) begin
        case (csr_addr)
          A_MSTATUS: begin mie_q <= csr_wdata[3]; mpie_q <= csr_wdata[7]; end
          A_MIE:     begin meie_q <= csr_wdata[11]; mtie_q <= csr_wdata[7]; end
          A_MTVEC:   mtvec_q  <= csr_wdata;
          A_MEPC:    mepc_q   <= {csr_wdata[31:2], 2'b00};
          A_MCAUSE:  mcause_q <= csr_wdata;
          A_MTVAL:   mtval_q  <= csr_wdata;
          default:   ;
        endcase
      end
      case (state_q)
        IDLE: if (evt_hit) begin
          state_q <= DRAIN;
          cnt_q   <= 3'(FLUSH_CYCLES - 1);
          ret_q   <= evt_ret;
          cause_q <= evt_cause;
          pc_q    <= ex_pc;
          tval_q  <= evt_tval;
        end
        DRAIN: begin
          if (cnt_q == 3'd0) state_q <= ret_q ? RETURN : ENTER;
          else               cnt_q   <= cnt_q - 3'd1;
        end
        ENTER: begin
          state_q  <= IDLE;
          mepc_q   <= {pc_q[31:2], 2'b00};
          mcause_q <= cause_q;
          mtval_q  <= tval_q;
          mpie_q   <= mie_q;
          mie_q    <= 1'b0;
        end
        RETURN: begin
          state_q <= IDLE;
          mie_q   <= mpie_q;
          mpie_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboarded bench for trap_controller: redirects are predicted when events
// are driven and matched (target and cycle) when redirect_valid appears.
module tb_trap_controller;
  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_inst;
  logic        ecall, ebreak, mret, illegal_instr;
  logic        irq_ext, irq_timer;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        stall, flush, redirect_valid, trap_active;
  logic [31:0] redirect_pc;

  trap_controller #(.FLUSH_CYCLES(FC), .RESET_MTVEC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_inst(ex_inst),
    .ecall(ecall), .ebreak(ebreak), .mret(mret), .illegal_instr(illegal_instr),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .trap_active(trap_active)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; int cyc; } exp_t;
  exp_t exp_q[$];
  int   cyc = 0;
  int   n_run = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && redirect_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("redir_unexpected", {31'h0, redirect_valid}, 32'h0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("redir_pc", redirect_pc, e.pc);
        chk("redir_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    step();
    csr_we = 1'b0;
  endtask

  task automatic csr_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a; #1;
    chk(tag, csr_rdata, exp);
  endtask

  task automatic clear_ev();
    ex_valid = 1'b0; ecall = 1'b0; ebreak = 1'b0; mret = 1'b0; illegal_instr = 1'b0;
  endtask

  // flg = {illegal, ebreak, ecall, mret}; called at posedge+1 of detection cycle T
  task automatic fire(input string tag, input logic [3:0] flg, input logic [31:0] pc,
                      input logic [31:0] inst, input bit exp_ev, input logic [31:0] exp_rpc,
                      input bit poke, input bit enter_wr);
    exp_t e;
    ex_valid = 1'b1; ex_pc = pc; ex_inst = inst;
    {illegal_instr, ebreak, ecall, mret} = flg;
    @(negedge clk);
    chk({tag, "_flush"}, {31'h0, flush}, {31'h0, exp_ev});
    chk({tag, "_stallT"}, {31'h0, stall}, {31'h0, exp_ev});
    if (exp_ev) begin
      e.pc = exp_rpc; e.cyc = cyc + FC + 1;
      exp_q.push_back(e);
    end
    step();
    clear_ev();
    if (poke) begin
      ex_valid = 1'b1; ebreak = 1'b1;
      @(negedge clk);
      chk({tag, "_poke_flush"}, {31'h0, flush}, 32'h0);
      chk({tag, "_poke_stall"}, {31'h0, stall}, 32'h1);
      step();
      clear_ev();
    end else step();
    repeat (FC - 1) step();
    if (enter_wr) begin
      csr_we = 1'b1; csr_addr = 12'h342; csr_wdata = 32'h55;
    end
    step();
    csr_we = 1'b0;
    chk({tag, "_stall_idle"}, {31'h0, stall}, 32'h0);
    chk({tag, "_active_idle"}, {31'h0, trap_active}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; clear_ev(); ex_pc = 0; ex_inst = 0;
    irq_ext = 0; irq_timer = 0; csr_we = 0; csr_addr = 0; csr_wdata = 0;
    step(); step();
    @(negedge clk);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_flush", {31'h0, flush}, 32'h0);
    chk("rst_rv", {31'h0, redirect_valid}, 32'h0);
    chk("rst_active", {31'h0, trap_active}, 32'h0);
    chk("rst_rpc", redirect_pc, 32'h0);
    step();
    rst_n = 1'b1;
    csr_chk("rst_mtvec", 12'h305, 32'h0);
    csr_chk("rst_mstatus", 12'h300, 32'h0);
    csr_chk("rst_mepc", 12'h341, 32'h0);

    // ECALL
    csr_wr(12'h305, 32'h200);
    csr_wr(12'h300, 32'h8);
    fire("ecall", 4'b0010, 32'h100, 32'h0, 1, 32'h200, 0, 0);
    csr_chk("ecall_mepc", 12'h341, 32'h100);
    csr_chk("ecall_mcause", 12'h342, 32'd11);
    csr_chk("ecall_mtval", 12'h343, 32'h0);
    csr_chk("ecall_mstatus", 12'h300, 32'h80);

    // Illegal beats a pending external interrupt
    csr_wr(12'h300, 32'h8);
    csr_wr(12'h304, 32'h800);
    irq_ext = 1'b1;
    csr_chk("mip_ext", 12'h344, 32'h800);
    fire("illegal", 4'b1000, 32'h10, 32'hFFFF_FFFF, 1, 32'h200, 0, 0);
    csr_chk("ill_mcause", 12'h342, 32'd2);
    csr_chk("ill_mtval", 12'h343, 32'hFFFF_FFFF);
    irq_ext = 1'b0;

    // Vectored timer interrupt, then masked by MIE=0
    csr_wr(12'h305, 32'h301);
    csr_wr(12'h304, 32'h80);
    csr_wr(12'h300, 32'h8);
    irq_timer = 1'b1;
    fire("timer", 4'b0000, 32'h44, 32'h0, 1, 32'h31C, 0, 0);
    csr_chk("tmr_mcause", 12'h342, 32'h8000_0007);
    csr_chk("tmr_mepc", 12'h341, 32'h44);
    fire("timer_masked", 4'b0000, 32'h48, 32'h0, 0, 32'h0, 0, 0);
    irq_timer = 1'b0;

    // MRET with an ebreak poked during DRAIN
    csr_wr(12'h341, 32'h104);
    fire("mret", 4'b0001, 32'h60, 32'h0, 1, 32'h104, 1, 0);
    csr_chk("mret_mstatus", 12'h300, 32'h88);

    // CSR collision in the ENTER cycle; mepc alignment; mip read-only
    fire("collide", 4'b0010, 32'h80, 32'h0, 1, 32'h300, 0, 1);
    csr_chk("collide_mcause", 12'h342, 32'd11);
    csr_wr(12'h341, 32'h123);
    csr_chk("mepc_align", 12'h341, 32'h120);
    csr_wr(12'h344, 32'hFFFF_FFFF);
    csr_chk("mip_ro", 12'h344, 32'h0);

    // Reset during DRAIN: no redirect, CSRs back to reset values
    ex_valid = 1'b1; ecall = 1'b1; ex_pc = 32'h400;
    @(negedge clk);
    chk("rstd_flush", {31'h0, flush}, 32'h1);
    step();
    clear_ev();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rstd_stall", {31'h0, stall}, 32'h0);
    chk("rstd_active", {31'h0, trap_active}, 32'h0);
    repeat (FC + 3) step();
    csr_chk("rstd_mepc", 12'h341, 32'h0);
    csr_chk("rstd_mcause", 12'h342, 32'h0);

    chk("sb_drained", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    chk("timeout", 32'h1, 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $fatal(1, "timeout");
  end
endmodule
